mem_stage: RTL

Memory-access stage of the pipelined core. Sits directly downstream of the execute stage and consumes its ALU result (the address), its forwarded store data and funct3. It drives a req/ack data-memory port, aligns and extends load data, and holds the upstream pipeline while an access is outstanding. It registers results into the MEM/WB outputs.

---
 rtl/mem_stage.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Issues aligned loads/stores on a req/ack
// port, aligns and extends load data, stalls upstream while an access is in
// flight and registers the retired result into the MEM/WB outputs.
module mem_stage #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_MemRead,
   input  logic        in_MemWrite,
   input  logic        in_RegWrite,
   input  logic [4:0]  in_rd,
   input  logic [2:0]  in_funct3,
   input  logic [63:0] in_ALU_out,
   input  logic [63:0] in_store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wstrb,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic [63:0] fwd_ALU_out,
   output logic        wb_valid,
   output logic        wb_RegWrite,
   output logic        wb_misalign,
   output logic        wb_fault,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_data
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [7:0]  r_waitCnt;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [63:0] r_loadData;
   logic [7:0]  r_wstrb;
   logic        r_we;
   logic        r_fault;
   logic [2:0]  r_funct3;
   logic [2:0]  r_lane;
   logic [4:0]  r_rd;

   logic        w_isMem;
   logic        w_isStore;
   logic        w_misalign;
   logic        w_issue;
   logic        w_timeout;
   logic [63:0] w_storeData;
   logic [7:0]  w_storeStrb;
   logic [63:0] w_shifted;
   logic [63:0] w_loadExt;

   // A store wins when both MemRead and MemWrite are set.
   assign w_isMem     = in_valid & (in_MemRead | in_MemWrite);
   assign w_isStore   = in_MemWrite;
   assign w_issue     = w_isMem & ~w_misalign;
   assign w_timeout   = (r_waitCnt == 8'(MAX_WAIT - 1));
   assign fwd_ALU_out = in_ALU_out;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign mem_wstrb   = r_wstrb;
   assign w_shifted   = mem_rdata >> {r_lane, 3'b000};

   // Alignment check against the access size encoded in funct3[1:0].
   always_comb begin
      w_misalign = 1'b0;
      case (in_funct3[1:0])
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = in_ALU_out[0];
         2'b10:   w_misalign = |in_ALU_out[1:0];
         default: w_misalign = |in_ALU_out[2:0];
      endcase
   end

   // Store lane replication and byte strobes for the current access size.
   always_comb begin
      w_storeData = in_store_data;
      w_storeStrb = 8'hFF;
      case (in_funct3[1:0])
         2'b00: begin
            w_storeData = {8{in_store_data[7:0]}};
            w_storeStrb = 8'h01 << in_ALU_out[2:0];
         end
         2'b01: begin
            w_storeData = {4{in_store_data[15:0]}};
            w_storeStrb = 8'h03 << in_ALU_out[2:0];
         end
         2'b10: begin
            w_storeData = {2{in_store_data[31:0]}};
            w_storeStrb = 8'h0F << in_ALU_out[2:0];
         end
         default: begin
            w_storeData = in_store_data;
            w_storeStrb = 8'hFF;
         end
      endcase
   end

   // Lane-selected read data extended according to the latched funct3.
   always_comb begin
      w_loadExt = w_shifted;
      case (r_funct3)
         3'b000:  w_loadExt = {{56{w_shifted[7]}},  w_shifted[7:0]};
         3'b001:  w_loadExt = {{48{w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_loadExt = {{32{w_shifted[31]}}, w_shifted[31:0]};
         3'b100:  w_loadExt = {56'd0, w_shifted[7:0]};
         3'b101:  w_loadExt = {48'd0, w_shifted[15:0]};
         3'b110:  w_loadExt = {32'd0, w_shifted[31:0]};
         default: w_loadExt = w_shifted;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   // Next state plus stall and request outputs; ack is only honoured in BUSY.
   always_comb begin
      w_nextState = r_state;
      stall       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_issue) begin
               stall       = 1'b1;
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            mem_we  = r_we;
            if (mem_ack || w_timeout) w_nextState = DONE;
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Latch the access at issue, count wait cycles and capture load data or fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waitCnt  <= 8'd0;
         r_addr     <= 64'd0;
         r_wdata    <= 64'd0;
         r_loadData <= 64'd0;
         r_wstrb    <= 8'd0;
         r_we       <= 1'b0;
         r_fault    <= 1'b0;
         r_funct3   <= 3'd0;
         r_lane     <= 3'd0;
         r_rd       <= 5'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_addr    <= {in_ALU_out[63:3], 3'b000};
                  r_wdata   <= w_isStore ? w_storeData : 64'd0;
                  r_wstrb   <= w_isStore ? w_storeStrb : 8'd0;
                  r_we      <= w_isStore;
                  r_funct3  <= in_funct3;
                  r_lane    <= in_ALU_out[2:0];
                  r_rd      <= in_rd;
                  r_waitCnt <= 8'd0;
                  r_fault   <= 1'b0;
               end
            end
            BUSY: begin
               if (mem_ack)        r_loadData <= w_loadExt;
               else if (w_timeout) r_fault    <= 1'b1;
               else                r_waitCnt  <= r_waitCnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // MEM/WB register: retire from DONE or a pass-through op, otherwise a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid    <= 1'b0;
         wb_RegWrite <= 1'b0;
         wb_misalign <= 1'b0;
         wb_fault    <= 1'b0;
         wb_rd       <= 5'd0;
         wb_data     <= 64'd0;
      end else if (r_state == DONE) begin
         wb_valid    <= in_valid;
         wb_rd       <= r_rd;
         wb_misalign <= 1'b0;
         wb_fault    <= r_fault;
         if (r_fault) begin
            wb_data     <= 64'd0;
            wb_RegWrite <= 1'b0;
         end else if (r_we) begin
            wb_data     <= in_ALU_out;
            wb_RegWrite <= 1'b0;
         end else begin
            wb_data     <= r_loadData;
            wb_RegWrite <= in_RegWrite & in_valid;
         end
      end else if (r_state == IDLE && !w_issue) begin
         wb_valid    <= in_valid;
         wb_rd       <= in_rd;
         wb_data     <= in_ALU_out;
         wb_fault    <= 1'b0;
         wb_misalign <= w_isMem & w_misalign;
         wb_RegWrite <= in_RegWrite & in_valid & ~(w_isMem & w_misalign);
      end else begin
         wb_valid    <= 1'b0;
         wb_RegWrite <= 1'b0;
         wb_misalign <= 1'b0;
         wb_fault    <= 1'b0;
      end
   end

endmodule
